dma_arbiter: RTL and testbench

Shares the single QBUS DMA master engine (qmaster2908) and its Am2908 address/data path between several DMA-capable device controllers, e.g. the RKV11 plus a future second disk controller.
- Accepts per-requester transfer requests and picks one by round-robin.
- Drives the master engine's read/write command and holds it until the engine reports completion.
- Routes completion and NXM status back to the winning requester.
- Sits between the device controllers and qmaster2908 in the top level, clocked by the 20 MHz QBUS clock.

---
 rtl/dma_arbiter.sv | 170 +++++++++++++++++
 tb/tb_dma_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dma_arbiter.sv
// Round-robin arbiter that shares the qmaster2908 DMA engine between NREQ device controllers.
// Optional hung-bus watchdog is enabled by defining ARB_WATCHDOG_EN.
module dma_arbiter #(
    parameter int unsigned NREQ        = 2,
    parameter int unsigned IDXW        = 3,
    parameter int unsigned WDOG_CYCLES = 4000
) (
    input  logic            clk20,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] req_write,
    output logic [NREQ-1:0] grant,
    output logic            dma_read,
    output logic            dma_write,
    input  logic            dma_complete,
    input  logic            dma_nxm,
    output logic [NREQ-1:0] done,
    output logic [NREQ-1:0] nxm,
    output logic            busy
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StBusy,
        StRelease
    } state_e;

    if ((1 << IDXW) < NREQ || NREQ < 1 || NREQ > 8 || WDOG_CYCLES < 1) begin : g_param_err
        $error("dma_arbiter: illegal parameter combination");
    end

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [IDXW-1:0]   last_q, last_d;
    logic              dir_q, dir_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [NREQ-1:0]   nxm_q, nxm_d;
    logic              timeout;

    logic              found;
    logic [IDXW-1:0]   win;
    logic [NREQ-1:0]   win_oh;
    logic [NREQ-1:0]   own_oh;

    // Search upward from last+1 with wrap; the first requester hit wins.
    always_comb begin
        found = 1'b0;
        win   = last_q;
        for (int k = 1; k <= int'(NREQ); k++) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (!found && req[i] && ((int'(last_q) + k) % int'(NREQ)) == i) begin
                    found = 1'b1;
                    win   = IDXW'(i);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            win_oh[i] = (win == IDXW'(i));
            own_oh[i] = (idx_q == IDXW'(i));
        end
    end

`ifdef ARB_WATCHDOG_EN
    localparam int unsigned CW = $clog2(WDOG_CYCLES + 1);

    logic [CW-1:0] wdog_q, wdog_d;

    // Counter rests at zero outside BUSY, so it is already clear on entry.
    always_comb begin
        wdog_d = '0;
        if (state_q == StBusy) begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    assign timeout = (state_q == StBusy) && (wdog_q == CW'(WDOG_CYCLES - 1));

    always_ff @(posedge clk20 or posedge reset) begin
        if (reset) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        dir_d   = dir_q;
        grant_d = grant_q;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        done_d  = '0;
        nxm_d   = '0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    idx_d   = win;
                    dir_d   = |(req_write & win_oh);
                    grant_d = win_oh;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                rd_d    = ~dir_q;
                wr_d    = dir_q;
                state_d = StBusy;
            end
            StBusy: begin
                if (dma_complete || timeout) begin
                    done_d  = own_oh;
                    nxm_d   = (dma_nxm || timeout) ? own_oh : '0;
                    last_d  = idx_q;
                    state_d = StRelease;
                end else begin
                    rd_d = ~dir_q;
                    wr_d = dir_q;
                end
            end
            StRelease: begin
                grant_d = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk20 or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            last_q  <= IDXW'(NREQ - 1);
            dir_q   <= 1'b0;
            grant_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            done_q  <= '0;
            nxm_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            dir_q   <= dir_d;
            grant_q <= grant_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            nxm_q   <= nxm_d;
        end
    end

    assign grant     = grant_q;
    assign dma_read  = rd_q;
    assign dma_write = wr_q;
    assign done      = done_q;
    assign nxm       = nxm_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_dma_arbiter.sv
// Directed self-checking bench for dma_arbiter with three requesters.
// Define ARB_WATCHDOG_EN for both files to exercise the 50-cycle watchdog.
module tb_dma_arbiter;

    localparam int unsigned NREQ = 3;

    logic            clk20 = 1'b0;
    logic            reset = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] req_write = '0;
    logic            dma_complete = 1'b0;
    logic            dma_nxm = 1'b0;
    logic [NREQ-1:0] grant;
    logic            dma_read;
    logic            dma_write;
    logic [NREQ-1:0] done;
    logic [NREQ-1:0] nxm;
    logic            busy;

    int checks = 0;
    int failures = 0;

    dma_arbiter #(
        .NREQ        (NREQ),
        .IDXW        (2),
        .WDOG_CYCLES (50)
    ) dut (
        .clk20        (clk20),
        .reset        (reset),
        .req          (req),
        .req_write    (req_write),
        .grant        (grant),
        .dma_read     (dma_read),
        .dma_write    (dma_write),
        .dma_complete (dma_complete),
        .dma_nxm      (dma_nxm),
        .done         (done),
        .nxm          (nxm),
        .busy         (busy)
    );

    always #25 clk20 = ~clk20;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk20);
        #1;
    endtask

    task automatic wait_grant(input string tag, input logic [NREQ-1:0] exp_g);
        int n = 0;
        while (grant == '0 && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_grant"}, 32'(grant), 32'(exp_g));
        chk({tag, "_onehot"}, 32'($countones(grant)), 32'd1);
    endtask

    task automatic wait_dma(input string tag, input logic exp_wr);
        int n = 0;
        while (!(dma_read || dma_write) && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_dma_write"}, 32'(dma_write), 32'(exp_wr));
        chk({tag, "_dma_read"}, 32'(dma_read), 32'(!exp_wr));
    endtask

    task automatic finish_xfer(input string tag, input logic [NREQ-1:0] exp_g,
                               input logic nxm_in, input logic rearm);
        dma_complete = 1'b1;
        dma_nxm      = nxm_in;
        tick();
        chk({tag, "_done"}, 32'(done), 32'(exp_g));
        chk({tag, "_nxm"}, 32'(nxm), nxm_in ? 32'(exp_g) : 32'd0);
        chk({tag, "_dma_off"}, 32'({dma_read, dma_write}), 32'd0);
        chk({tag, "_grant_rel"}, 32'(grant), 32'(exp_g));
        dma_complete = 1'b0;
        dma_nxm      = 1'b0;
        req          = req & ~exp_g;
        tick();
        chk({tag, "_grant_clr"}, 32'(grant), 32'd0);
        chk({tag, "_done_clr"}, 32'(done), 32'd0);
        if (rearm) req = req | exp_g;
    endtask

    initial begin
        // Reset: requests are ignored while reset is held
        req = 3'b001;
        #60;
        chk("reset_outs", 32'({grant, done, nxm, dma_read, dma_write, busy}), 32'd0);
        tick();
        chk("reset_grant", 32'(grant), 32'd0);
        req = '0;
        @(negedge clk20);
        reset = 1'b0;

        // Latency: req raised just after edge 1, grant at edge 2, dma_read at edge 3
        @(posedge clk20);
        #1;
        req       = 3'b001;
        req_write = 3'b000;
        chk("t1_e1_grant", 32'(grant), 32'd0);
        tick();
        chk("t1_e2_grant", 32'(grant), 32'b001);
        chk("t1_e2_busy", 32'(busy), 32'd1);
        chk("t1_e2_read", 32'(dma_read), 32'd0);
        tick();
        chk("t1_e3_read", 32'(dma_read), 32'd1);
        chk("t1_e3_write", 32'(dma_write), 32'd0);
        tick();
        tick();
        chk("t1_hold_read", 32'(dma_read), 32'd1);
        finish_xfer("t1", 3'b001, 1'b0, 1'b0);

        // Completion outside BUSY is ignored
        dma_complete = 1'b1;
        dma_nxm      = 1'b1;
        tick();
        chk("idle_cmpl", 32'({done, nxm, busy}), 32'd0);
        dma_complete = 1'b0;
        dma_nxm      = 1'b0;

        // Rotation with 0 and 1 asserting; last served was 0
        req = 3'b011;
        wait_grant("t2a", 3'b010);
        wait_dma("t2a", 1'b0);
        finish_xfer("t2a", 3'b010, 1'b0, 1'b1);
        wait_grant("t2b", 3'b001);
        wait_dma("t2b", 1'b0);
        finish_xfer("t2b", 3'b001, 1'b0, 1'b1);
        wait_grant("t2c", 3'b010);
        wait_dma("t2c", 1'b0);
        finish_xfer("t2c", 3'b010, 1'b0, 1'b1);
        wait_grant("t2d", 3'b001);
        wait_dma("t2d", 1'b0);
        finish_xfer("t2d", 3'b001, 1'b0, 1'b0);
        wait_grant("t2e", 3'b010);
        wait_dma("t2e", 1'b0);
        finish_xfer("t2e", 3'b010, 1'b0, 1'b0);

        // Wrap: serve 2, then 0 wins over 1
        req = 3'b100;
        wait_grant("t3a", 3'b100);
        wait_dma("t3a", 1'b0);
        finish_xfer("t3a", 3'b100, 1'b0, 1'b0);
        req       = 3'b011;
        req_write = 3'b010;
        wait_grant("t3b", 3'b001);
        wait_dma("t3b", 1'b0);
        finish_xfer("t3b", 3'b001, 1'b0, 1'b0);

        // NXM routed to requester 1, which is doing a write
        wait_grant("t4", 3'b010);
        wait_dma("t4", 1'b1);
        finish_xfer("t4", 3'b010, 1'b1, 1'b0);

        // req drop and direction change mid-BUSY do not disturb the transfer
        req       = 3'b001;
        req_write = 3'b000;
        wait_grant("t5", 3'b001);
        wait_dma("t5", 1'b0);
        req       = 3'b000;
        req_write = 3'b001;
        tick();
        tick();
        tick();
        chk("t5_hold", 32'({dma_read, dma_write}), 32'b10);
        finish_xfer("t5", 3'b001, 1'b0, 1'b0);
        req_write = 3'b000;

        // Reset mid-transfer abandons it and restores the last pointer
        req = 3'b010;
        wait_grant("t6a", 3'b010);
        wait_dma("t6a", 1'b0);
        #5;
        reset = 1'b1;
        #1;
        chk("t6_rst_outs", 32'({grant, done, nxm, dma_read, dma_write, busy}), 32'd0);
        req = 3'b000;
        @(negedge clk20);
        reset = 1'b0;
        req   = 3'b011;
        wait_grant("t6b", 3'b001);
        wait_dma("t6b", 1'b0);
        finish_xfer("t6b", 3'b001, 1'b0, 1'b0);
        wait_grant("t6c", 3'b010);
        wait_dma("t6c", 1'b0);
        finish_xfer("t6c", 3'b010, 1'b0, 1'b0);

        // Hung transfer: no dma_complete
        req = 3'b001;
        wait_grant("t7", 3'b001);
        wait_dma("t7", 1'b0);
`ifdef ARB_WATCHDOG_EN
        repeat (49) tick();
        chk("t7_wd_pre_done", 32'(done), 32'd0);
        chk("t7_wd_pre_read", 32'(dma_read), 32'd1);
        tick();
        chk("t7_wd_done", 32'(done), 32'b001);
        chk("t7_wd_nxm", 32'(nxm), 32'b001);
        req = 3'b000;
        tick();
        chk("t7_wd_grant_clr", 32'(grant), 32'd0);
`else
        repeat (60) tick();
        chk("t7_wait_read", 32'(dma_read), 32'd1);
        chk("t7_wait_done", 32'(done), 32'd0);
        finish_xfer("t7", 3'b001, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
